// File: rtl/axis_flit_deserializer.sv
// NoC egress endpoint: buffers router flits in a credit-backed FIFO and
// reassembles SERIALIZATION_FACTOR flits into one AXI-Stream beat.
module axis_flit_deserializer #(
  parameter int TDEST_WIDTH          = 6,
  parameter int TDATA_WIDTH          = 512,
  parameter int SERIALIZATION_FACTOR = 4,
  parameter int FLIT_BUFFER_DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [TDATA_WIDTH/SERIALIZATION_FACTOR-1:0] data_in,
  input  logic [TDEST_WIDTH-1:0]     dest_in,
  input  logic                       is_tail_in,
  input  logic                       send_in,
  output logic                       credit_out,
  output logic                       axis_tvalid,
  input  logic                       axis_tready,
  output logic [TDATA_WIDTH-1:0]     axis_tdata,
  output logic                       axis_tlast,
  output logic [TDEST_WIDTH-1:0]     axis_tdest,
  output logic                       err_overflow,
  output logic                       err_protocol
);

  localparam int FW     = TDATA_WIDTH / SERIALIZATION_FACTOR;
  localparam int SF     = SERIALIZATION_FACTOR;
  localparam int DEPTH  = FLIT_BUFFER_DEPTH;
  localparam int CNT_W  = (SF > 1) ? $clog2(SF) : 1;
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FCNT_W = $clog2(DEPTH + 1);

  logic [FW-1:0]          fifo_data [DEPTH];
  logic [TDEST_WIDTH-1:0] fifo_dest [DEPTH];
  logic                   fifo_tail [DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [FCNT_W-1:0]      fifo_cnt;

  logic [CNT_W-1:0]       cnt;
  logic [TDATA_WIDTH-1:0] beat_stage_p0;
  logic [TDATA_WIDTH-1:0] beat_next;

  logic                   fifo_empty;
  logic                   fifo_full;
  logic [FW-1:0]          head_data;
  logic [TDEST_WIDTH-1:0] head_dest;
  logic                   head_tail;
  logic                   last_slot;
  logic                   closes;
  logic                   out_free;
  logic                   pop;
  logic                   push_ok;
  logic                   overflow_hit;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == FCNT_W'(DEPTH));
  assign head_data  = fifo_data[rd_ptr];
  assign head_dest  = fifo_dest[rd_ptr];
  assign head_tail  = fifo_tail[rd_ptr];
  assign last_slot  = (cnt == CNT_W'(SF - 1));

  // A flit that closes a beat needs the output register to be free or draining.
  assign closes       = last_slot || head_tail;
  assign out_free     = !axis_tvalid || axis_tready;
  assign pop          = !fifo_empty && (!closes || out_free);
  assign push_ok      = send_in && (!fifo_full || pop);
  assign overflow_hit = send_in && fifo_full && !pop;

  // Slices below cnt come from staging, slice cnt is the head flit, the rest are zero.
  always_comb begin
    beat_next = '0;
    for (int i = 0; i < SF; i++) begin
      if (i < int'(cnt)) begin
        beat_next[i*FW +: FW] = beat_stage_p0[i*FW +: FW];
      end else if (i == int'(cnt)) begin
        beat_next[i*FW +: FW] = head_data;
      end
    end
  end

  // Stage p0: flit FIFO storage and partial-beat staging (data only, no reset)
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_data[wr_ptr] <= data_in;
      fifo_dest[wr_ptr] <= dest_in;
      fifo_tail[wr_ptr] <= is_tail_in;
    end
    if (pop && !closes) begin
      beat_stage_p0[int'(cnt)*FW +: FW] <= head_data;
    end
  end

  // Stage p1: FIFO control, slot counter, output beat register, credits, errors
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_cnt     <= '0;
      cnt          <= '0;
      credit_out   <= 1'b0;
      axis_tvalid  <= 1'b0;
      axis_tdata   <= '0;
      axis_tlast   <= 1'b0;
      axis_tdest   <= '0;
      err_overflow <= 1'b0;
      err_protocol <= 1'b0;
    end else begin
      credit_out <= pop;
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)     rd_ptr <= ptr_inc(rd_ptr);
      case ({push_ok, pop})
        2'b10:   fifo_cnt <= fifo_cnt + FCNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - FCNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (pop) cnt <= closes ? '0 : cnt + CNT_W'(1);
      if (pop && closes) begin
        axis_tvalid <= 1'b1;
        axis_tdata  <= beat_next;
        axis_tlast  <= head_tail;
        axis_tdest  <= head_dest;
      end else if (axis_tready) begin
        axis_tvalid <= 1'b0;
      end
      if (overflow_hit) err_overflow <= 1'b1;
      if (pop && head_tail && !last_slot) err_protocol <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axis_flit_deserializer.sv
// Directed bench for axis_flit_deserializer with a packet-level beat model
// and a per-cycle compare process on the AXI-Stream output.
module tb_axis_flit_deserializer;

  localparam int TDW = 6;
  localparam int TW  = 512;
  localparam int SF  = 4;
  localparam int DEP = 4;
  localparam int FW  = TW / SF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [FW-1:0] data_in = '0;
  logic [TDW-1:0] dest_in = '0;
  logic          is_tail_in = 1'b0;
  logic          send_in = 1'b0;
  logic          credit_out;
  logic          axis_tvalid;
  logic          axis_tready = 1'b0;
  logic [TW-1:0] axis_tdata;
  logic          axis_tlast;
  logic [TDW-1:0] axis_tdest;
  logic          err_overflow;
  logic          err_protocol;

  axis_flit_deserializer #(
    .TDEST_WIDTH(TDW), .TDATA_WIDTH(TW),
    .SERIALIZATION_FACTOR(SF), .FLIT_BUFFER_DEPTH(DEP)
  ) dut (
    .clk(clk), .rst(rst),
    .data_in(data_in), .dest_in(dest_in), .is_tail_in(is_tail_in), .send_in(send_in),
    .credit_out(credit_out),
    .axis_tvalid(axis_tvalid), .axis_tready(axis_tready), .axis_tdata(axis_tdata),
    .axis_tlast(axis_tlast), .axis_tdest(axis_tdest),
    .err_overflow(err_overflow), .err_protocol(err_protocol)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TW-1:0]  data;
    logic [TDW-1:0] dest;
    logic           last;
  } beat_t;

  beat_t          exp_q[$];
  logic [TW-1:0]  part = '0;
  int             part_n = 0;
  int             total = 0;
  int             bad = 0;
  int             credit_cnt = 0;
  int             run = 0;
  int             max_run = 0;
  int             cyc = 0;
  int             hs_cyc[$];
  logic           held = 1'b0;
  logic [TW-1:0]  prev_data;
  logic           prev_last;
  logic [TDW-1:0] prev_dest;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Packet-level model: flits fill a beat LSB-first until SF flits or a tail.
  task automatic model_push(input logic [FW-1:0] d, input logic [TDW-1:0] dst, input logic tail);
    beat_t b;
    part[part_n*FW +: FW] = d;
    part_n++;
    if (part_n == SF || tail) begin
      b.data = part;
      b.dest = dst;
      b.last = tail;
      exp_q.push_back(b);
      part   = '0;
      part_n = 0;
    end
  endtask

  function automatic logic [FW-1:0] fl(input int b, input int i);
    logic [31:0] w;
    w = 32'h5A000000 | 32'(b * 256 + i);
    return {4{w}};
  endfunction

  task automatic send(input logic [FW-1:0] d, input logic [TDW-1:0] dst, input logic tail,
                      input bit kept);
    @(posedge clk); #1;
    data_in    = d;
    dest_in    = dst;
    is_tail_in = tail;
    send_in    = 1'b1;
    if (kept) model_push(d, dst, tail);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      send_in    = 1'b0;
      is_tail_in = 1'b0;
    end
  endtask

  task automatic drain(input int lim);
    int n = 0;
    while (exp_q.size() != 0 && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk_int("drain_expected_beats_left", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst        = 1'b1;
    send_in    = 1'b0;
    is_tail_in = 1'b0;
    exp_q.delete();
    part   = '0;
    part_n = 0;
    #2;
    chk("rst_tdata", axis_tdata, '0);
    chk_int("rst_ctrl", int'({credit_out, axis_tvalid, axis_tlast, err_overflow, err_protocol}), 0);
    chk_int("rst_tdest", int'(axis_tdest), 0);
    repeat (2) @(posedge clk);
    #1;
    credit_cnt = 0;
    run        = 0;
    max_run    = 0;
    hs_cyc.delete();
    rst = 1'b0;
  endtask

  // Compare process: output beats against the model, hold stability, credit tally.
  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else begin
      if (credit_out) begin
        credit_cnt++;
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      if (held) begin
        chk_int("hold_tvalid", int'(axis_tvalid), 1);
        chk("hold_tdata", axis_tdata, prev_data);
        chk_int("hold_tlast_tdest", int'({axis_tlast, axis_tdest}), int'({prev_last, prev_dest}));
      end
      if (axis_tvalid && axis_tready) begin
        if (exp_q.size() == 0) begin
          chk_int("unexpected_beat", 1, 0);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("beat_tdata", axis_tdata, e.data);
          chk_int("beat_tlast", int'(axis_tlast), int'(e.last));
          chk_int("beat_tdest", int'(axis_tdest), int'(e.dest));
        end
        hs_cyc.push_back(cyc);
      end
      held      = axis_tvalid && !axis_tready;
      prev_data = axis_tdata;
      prev_last = axis_tlast;
      prev_dest = axis_tdest;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [FW-1:0] fa, fb, fc, fd, f0, f1;
    fa = {32{4'hA}};
    fb = {32{4'hB}};
    fc = {32{4'hC}};
    fd = {32{4'hD}};

    // Single beat, latency and credits
    do_reset();
    axis_tready = 1'b1;
    send(fa, 6'h15, 1'b0, 1'b1);
    send(fb, 6'h15, 1'b0, 1'b1);
    send(fc, 6'h15, 1'b0, 1'b1);
    send(fd, 6'h15, 1'b1, 1'b1);
    idle(1);
    @(negedge clk);
    chk_int("t1_tvalid_n_plus_1", int'(axis_tvalid), 0);
    idle(1);
    @(negedge clk);
    chk_int("t1_tvalid_n_plus_2", int'(axis_tvalid), 1);
    chk("t1_tdata_literal", axis_tdata, {fd, fc, fb, fa});
    chk_int("t1_tlast_literal", int'(axis_tlast), 1);
    chk_int("t1_tdest_literal", int'(axis_tdest), 'h15);
    idle(3);
    chk_int("t1_credits", credit_cnt, 4);
    drain(10);

    // Three beats streamed back-to-back
    hs_cyc.delete();
    max_run = 0;
    for (int b = 0; b < 3; b++)
      for (int i = 0; i < SF; i++)
        send(fl(b, i), 6'(b + 1), i == SF - 1, 1'b1);
    idle(1);
    drain(20);
    idle(2);
    chk_int("t2_beat_count", hs_cyc.size(), 3);
    if (hs_cyc.size() == 3) begin
      chk_int("t2_spacing_01", hs_cyc[1] - hs_cyc[0], 4);
      chk_int("t2_spacing_12", hs_cyc[2] - hs_cyc[1], 4);
    end
    chk_int("t2_credit_run", max_run, 12);

    // Output stalled: staging continues, closing flit waits in FIFO
    do_reset();
    axis_tready = 1'b0;
    for (int i = 0; i < 8; i++)
      send(fl(10 + i / SF, i), 6'h2A, i % SF == SF - 1, 1'b1);
    idle(6);
    @(negedge clk);
    chk_int("t3_credits_stalled", credit_cnt, 7);
    chk_int("t3_tvalid_stalled", int'(axis_tvalid), 1);
    @(posedge clk); #1;
    axis_tready = 1'b1;
    drain(20);
    idle(2);
    chk_int("t3_credits_total", credit_cnt, 8);
    if (hs_cyc.size() == 2) chk_int("t3_beat2_next_cycle", hs_cyc[1] - hs_cyc[0], 1);
    else chk_int("t3_beat_count", hs_cyc.size(), 2);

    // Early tail on flit index 1
    do_reset();
    axis_tready = 1'b1;
    f0 = fl(20, 0);
    f1 = fl(20, 1);
    send(f0, 6'h03, 1'b0, 1'b1);
    send(f1, 6'h03, 1'b1, 1'b1);
    idle(2);
    @(negedge clk);
    chk_int("t4_tvalid", int'(axis_tvalid), 1);
    chk("t4_tdata_literal", axis_tdata, {{(2*FW){1'b0}}, f1, f0});
    chk_int("t4_tlast", int'(axis_tlast), 1);
    idle(2);
    chk_int("t4_err_protocol", int'(err_protocol), 1);
    for (int i = 0; i < SF; i++) send(fl(21, i), 6'h04, i == SF - 1, 1'b1);
    idle(2);
    drain(10);
    chk_int("t4_err_protocol_sticky", int'(err_protocol), 1);
    chk_int("t4_err_overflow_clear", int'(err_overflow), 0);

    // Overflow: push while full drops the flit
    do_reset();
    chk_int("t5_err_protocol_cleared", int'(err_protocol), 0);
    axis_tready = 1'b0;
    for (int i = 0; i < 12; i++)
      send(fl(30 + i / SF, i), 6'h11, i % SF == SF - 1, i != 11);
    idle(3);
    chk_int("t5_err_overflow", int'(err_overflow), 1);
    chk_int("t5_credits_stalled", credit_cnt, 7);
    @(posedge clk); #1;
    axis_tready = 1'b1;
    drain(20);
    idle(4);
    chk_int("t5_credits_total", credit_cnt, 11);
    chk_int("t5_err_overflow_sticky", int'(err_overflow), 1);

    // Reset mid-beat, then a fresh beat
    do_reset();
    axis_tready = 1'b0;
    for (int i = 0; i < 6; i++) send(fl(40, i), 6'h09, i == SF - 1, 1'b1);
    idle(3);
    @(negedge clk);
    chk_int("t6_tvalid_before_rst", int'(axis_tvalid), 1);
    do_reset();
    axis_tready = 1'b1;
    for (int i = 0; i < SF; i++) send(fl(41, i), 6'h0C, i == SF - 1, 1'b1);
    idle(2);
    drain(10);
    idle(2);
    chk_int("t6_credits_after_rst", credit_cnt, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
